// File: rtl/axi_refill_pkg.sv
// Shared types and constants for the cache-line refill AXI read master.
// Holds AXI encodings, the refill FSM state type and the AxSIZE helper.
package axi_refill_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Line assembly buffer: LINE_WORDS x DATA_WIDTH registers, one word
// written per beat, presented as a single flat line.
module refill_line_buffer #(
    parameter int LINE_WORDS = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_idx,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] line
);

    logic [DATA_WIDTH-1:0] word_q [LINE_WORDS];
    logic [DATA_WIDTH-1:0] word_d [LINE_WORDS];

    always_comb begin
        word_d = word_q;
        if (wr_en) begin
            word_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '{default: '0};
        end else begin
            word_q <= word_d;
        end
    end

    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_flat
        assign line[i*DATA_WIDTH +: DATA_WIDTH] = word_q[i];
    end

endmodule

// File: rtl/axi_line_refill.sv
// AXI4 read master that fetches one aligned cache line per request.
// Define LINE_REFILL_RESP_CHECK_EN to build rresp / rlast error checking.
module axi_line_refill
    import axi_refill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int LINE_WORDS = 8,
    parameter int ARID_VALUE = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             resp_valid,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_data,
    output logic                             resp_err,
    output logic [ID_WIDTH-1:0]              m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready
);

    localparam int OFFSET = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int IDX_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int CNT_W  = $clog2(LINE_WORDS) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    refill_state_t         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  req_ready_q, req_ready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  accept;
    logic                  beat;
    logic                  wr_en;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;
    assign beat   = m_axi_rvalid && rready_q;
    // Beats past the end of the line are dropped so the count never wraps
    assign wr_en  = beat && (cnt_q < CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        araddr_d = araddr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = AR;
                    araddr_d = req_addr & ALIGN_MASK;
                    cnt_d    = '0;
                end
            end
            AR: begin
                if (m_axi_arready && arvalid_q) begin
                    state_d = R;
                end
            end
            R: begin
                if (beat) begin
                    if (wr_en) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (m_axi_rlast) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered off the next state, so no input reaches an output
    assign req_ready_d  = (state_d == IDLE);
    assign arvalid_d    = (state_d == AR);
    assign rready_d     = (state_d == R);
    assign resp_valid_d = (state_d == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            araddr_q     <= '0;
            req_ready_q  <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            araddr_q     <= araddr_d;
            req_ready_q  <= req_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

`ifdef LINE_REFILL_RESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (beat) begin
            if ((m_axi_rresp != AXI_RESP_OKAY) ||
                (m_axi_rlast && (cnt_q != CNT_LAST))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign resp_err = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^m_axi_rresp;
    assign resp_err     = 1'b0;
`endif

    refill_line_buffer #(
        .LINE_WORDS(LINE_WORDS),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (cnt_q[IDX_W-1:0]),
        .wr_data(m_axi_rdata),
        .line   (resp_data)
    );

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign m_axi_arid    = ID_WIDTH'(ARID_VALUE);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = axi_size(DATA_WIDTH);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_line_refill.sv
// Self-checking bench for axi_line_refill with a randomised AXI RAM slave
// and a line-level reference model of the expected refill results.
module tb_axi_line_refill;

    localparam int LW = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LB = LW * DW / 8;
`ifdef LINE_REFILL_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          resp_valid;
    logic [LW*DW-1:0] resp_data;
    logic          resp_err;
    logic [7:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    always #5 clk = ~clk;

    axi_line_refill #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(8),
        .LINE_WORDS(LW), .ARID_VALUE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Slave configuration, written only by the stimulus process
    int cfg_stall    = 0;
    int cfg_gap_max  = 0;
    int cfg_err_beat = -1;
    int cfg_nbeats   = LW;
    logic [31:0] seed = 32'h1357_9bdf;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0] ^ seed[31:16], ~a[15:0] ^ seed[15:0]};
    endfunction

    // AXI RAM slave model
    logic          s_busy = 1'b0;
    logic [AW-1:0] s_addr = '0;
    int            s_beat = 0;
    int            s_gap = 0;
    int            s_wait = 0;
    int            s_next_gap = 0;

    always @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
            s_busy  <= 1'b0;
            s_beat  <= 0;
            s_gap   <= 0;
            s_wait  <= 0;
        end else if (!s_busy) begin
            if (arvalid && arready) begin
                s_busy     <= 1'b1;
                s_addr     <= araddr;
                s_beat     <= 0;
                s_gap      <= 0;
                s_wait     <= 0;
                arready    <= 1'b0;
                s_next_gap <= (cfg_gap_max > 0) ?
                    int'($urandom_range(cfg_gap_max, 1)) : 0;
            end else if (arvalid) begin
                s_wait  <= s_wait + 1;
                arready <= (s_wait + 1 >= cfg_stall);
            end else begin
                s_wait  <= 0;
                arready <= (cfg_stall == 0);
            end
        end else if (rvalid && rready) begin
            s_beat <= s_beat + 1;
            if (rlast) begin
                rvalid <= 1'b0;
                s_busy <= 1'b0;
            end else if (s_next_gap == 0) begin
                rvalid <= 1'b1;
                rdata  <= mem_word(s_addr + AW'((s_beat + 1) * (DW / 8)));
                rresp  <= (s_beat + 1 == cfg_err_beat) ? 2'b10 : 2'b00;
                rlast  <= (s_beat + 1 == cfg_nbeats - 1);
            end else begin
                rvalid <= 1'b0;
                s_gap  <= s_next_gap - 1;
            end
            s_next_gap <= (cfg_gap_max > 0) ?
                int'($urandom_range(cfg_gap_max, 1)) : 0;
        end else if (!rvalid) begin
            if (s_gap > 0) begin
                s_gap <= s_gap - 1;
            end else begin
                rvalid <= 1'b1;
                rdata  <= mem_word(s_addr + AW'(s_beat * (DW / 8)));
                rresp  <= (s_beat == cfg_err_beat) ? 2'b10 : 2'b00;
                rlast  <= (s_beat == cfg_nbeats - 1);
            end
        end
    end

    // Reference model: the line buffer contents the cache should see
    logic [DW-1:0] ml [LW];

    task automatic model_clear();
        for (int i = 0; i < LW; i++) ml[i] = '0;
    endtask

    task automatic model_apply(input logic [AW-1:0] addr, input int nb);
        logic [AW-1:0] base;
        base = addr - (addr % LB);
        for (int i = 0; i < LW && i < nb; i++) begin
            ml[i] = mem_word(base + AW'(i * (DW / 8)));
        end
    endtask

    function automatic logic [LW*DW-1:0] model_flat();
        logic [LW*DW-1:0] f;
        for (int i = 0; i < LW; i++) f[i*DW +: DW] = ml[i];
        return f;
    endfunction

    // Observations gathered by refill()
    int               obs_lat;
    int               obs_plen;
    logic [LW*DW-1:0] obs_data;
    logic             obs_err;
    logic             obs_to;
    logic             obs_ar_bad;
    logic             obs_rr_early;
    logic             obs_busy_rdy;
    logic             obs_rdy_after;
    logic             obs_unstable;
    logic [AW-1:0]    obs_araddr;
    logic [7:0]       obs_arlen;
    logic [2:0]       obs_arsize;
    logic [1:0]       obs_arburst;
    logic [7:0]       obs_arid;

    task automatic refill(input logic [AW-1:0] addr);
        int  k;
        int  t;
        bit  ar_hs;
        bit  done;
        obs_lat = -1; obs_plen = 0; obs_data = '0; obs_err = 1'b0;
        obs_to = 1'b0; obs_ar_bad = 1'b0; obs_rr_early = 1'b0;
        obs_busy_rdy = 1'b0; obs_rdy_after = 1'b0; obs_unstable = 1'b0;
        @(negedge clk);
        req_addr  = addr;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            obs_to    = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid   = 1'b0;
        t           = 1;
        obs_araddr  = araddr;
        obs_arlen   = arlen;
        obs_arsize  = arsize;
        obs_arburst = arburst;
        obs_arid    = arid;
        ar_hs       = 1'b0;
        done        = 1'b0;
        while (!done && t < 400) begin
            if (!ar_hs) begin
                if (!arvalid || araddr !== obs_araddr) obs_ar_bad = 1'b1;
                if (rready) obs_rr_early = 1'b1;
                if (arvalid && arready) ar_hs = 1'b1;
            end
            if (resp_valid) begin
                if (obs_plen == 0) begin
                    obs_lat  = t;
                    obs_data = resp_data;
                    obs_err  = resp_err;
                end else if (resp_data !== obs_data || resp_err !== obs_err) begin
                    obs_unstable = 1'b1;
                end
                obs_plen++;
            end else if (obs_plen > 0) begin
                obs_rdy_after = req_ready;
                done = 1'b1;
            end else if (req_ready) begin
                obs_busy_rdy = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                t++;
            end
        end
        if (!done) obs_to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, arvalid, rready} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 00000",
                {req_ready, resp_valid, resp_err, arvalid, rready});
        end
        n_cmp++;
        if (araddr !== '0 || resp_data !== '0) begin
            n_bad++;
            $display("FAIL reset_regs araddr %h data %h want 0", araddr, resp_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_rise got %b want 1", req_ready);
        end
        model_clear();
    endtask

    task automatic test_basic();
        refill(32'h0000_1234);
        model_apply(32'h0000_1234, LW);
        n_cmp++;
        if (obs_to !== 1'b0) begin
            n_bad++; $display("FAIL basic_timeout got %b want 0", obs_to);
        end
        n_cmp++;
        if ({obs_araddr, obs_arlen, obs_arsize, obs_arburst, obs_arid} !==
            {32'h0000_1220, 8'd7, 3'd2, 2'b01, 8'd0}) begin
            n_bad++;
            $display("FAIL basic_ar got addr %h len %0d size %0d burst %0d id %0d want 1220 7 2 1 0",
                obs_araddr, obs_arlen, obs_arsize, obs_arburst, obs_arid);
        end
        n_cmp++;
        if (obs_lat !== 11) begin
            n_bad++; $display("FAIL basic_latency got %0d want 11", obs_lat);
        end
        n_cmp++;
        if (obs_data !== model_flat()) begin
            n_bad++; $display("FAIL basic_data got %h want %h", obs_data, model_flat());
        end
        n_cmp++;
        if ({obs_err, obs_plen, obs_rdy_after, obs_unstable} !== {1'b0, 32'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_pulse err %b len %0d rdy %b unst %b want 0 1 1 0",
                obs_err, obs_plen, obs_rdy_after, obs_unstable);
        end
    endtask

    task automatic test_ar_stall();
        logic [AW-1:0] a;
        a = $urandom;
        cfg_stall = 5;
        refill(a);
        cfg_stall = 0;
        model_apply(a, LW);
        n_cmp++;
        if ({obs_ar_bad, obs_rr_early} !== 2'b00) begin
            n_bad++;
            $display("FAIL stall_ar_stable ar_bad %b rready_early %b want 0 0",
                obs_ar_bad, obs_rr_early);
        end
        n_cmp++;
        if (obs_araddr !== a - (a % LB)) begin
            n_bad++; $display("FAIL stall_araddr got %h want %h", obs_araddr, a - (a % LB));
        end
        n_cmp++;
        if (obs_lat !== 11 + 5) begin
            n_bad++; $display("FAIL stall_latency got %0d want 16", obs_lat);
        end
        n_cmp++;
        if (obs_data !== model_flat()) begin
            n_bad++; $display("FAIL stall_data got %h want %h", obs_data, model_flat());
        end
    endtask

    task automatic test_gaps();
        logic [AW-1:0] a;
        cfg_gap_max = 3;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            refill(a);
            model_apply(a, LW);
            n_cmp++;
            if (obs_data !== model_flat()) begin
                n_bad++; $display("FAIL gaps_data[%0d] got %h want %h", i, obs_data, model_flat());
            end
            n_cmp++;
            if ({obs_plen, obs_busy_rdy, obs_rdy_after, obs_to} !== {32'd1, 1'b0, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL gaps_handshake[%0d] len %0d busy_rdy %b rdy %b to %b want 1 0 1 0",
                    i, obs_plen, obs_busy_rdy, obs_rdy_after, obs_to);
            end
        end
        cfg_gap_max = 0;
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 6; i++) begin
            a           = $urandom;
            cfg_gap_max = int'($urandom_range(3, 0));
            cfg_stall   = int'($urandom_range(3, 0));
            refill(a);
            model_apply(a, LW);
            n_cmp++;
            if (obs_data !== model_flat() || obs_err !== 1'b0 || obs_plen !== 1) begin
                n_bad++;
                $display("FAIL random[%0d] data %h err %b len %0d want %h 0 1",
                    i, obs_data, obs_err, obs_plen, model_flat());
            end
        end
        cfg_gap_max = 0;
        cfg_stall   = 0;
    endtask

    task automatic test_back_to_back();
        logic [LW*DW-1:0] exp1;
        logic [LW*DW-1:0] exp2;
        logic [LW*DW-1:0] d1;
        logic             r0;
        logic             r1;
        int               k;
        model_apply(32'h40, LW);
        exp1 = model_flat();
        model_apply(32'h80, LW);
        exp2 = model_flat();
        @(negedge clk);
        req_addr  = 32'h40;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        req_addr = 32'h80;
        k = 0;
        while (!resp_valid && k < 100) begin @(negedge clk); k++; end
        d1 = resp_data;
        r0 = req_ready;
        @(negedge clk);
        r1 = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 100) begin @(negedge clk); k++; end
        n_cmp++;
        if (d1 !== exp1) begin
            n_bad++; $display("FAIL b2b_first_data got %h want %h", d1, exp1);
        end
        n_cmp++;
        if ({r0, r1} !== 2'b01) begin
            n_bad++; $display("FAIL b2b_ready_after_done got %b want 01", {r0, r1});
        end
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== exp2) begin
            n_bad++;
            $display("FAIL b2b_second_data valid %b got %h want %h", resp_valid, resp_data, exp2);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [AW-1:0] a;
        int            nb [3];
        int            eb [3];
        nb = '{LW, 5, LW + 2};
        eb = '{3, -1, -1};
        for (int i = 0; i < 3; i++) begin
            a            = $urandom;
            cfg_nbeats   = nb[i];
            cfg_err_beat = eb[i];
            refill(a);
            model_apply(a, nb[i]);
            n_cmp++;
            if (obs_err !== CHK || obs_plen !== 1) begin
                n_bad++;
                $display("FAIL err_case[%0d] err %b len %0d want %b 1", i, obs_err, obs_plen, CHK);
            end
            n_cmp++;
            if (obs_data !== model_flat()) begin
                n_bad++;
                $display("FAIL err_data[%0d] got %h want %h", i, obs_data, model_flat());
            end
        end
        cfg_nbeats   = LW;
        cfg_err_beat = -1;
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        int            k;
        int            nbeat;
        @(negedge clk);
        req_addr  = $urandom;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        req_valid = 1'b0;
        nbeat = 0;
        k = 0;
        while (k < 100) begin
            if (rvalid && rready) begin
                if (nbeat == 3) break;
                nbeat++;
            end
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (nbeat !== 3) begin
            n_bad++; $display("FAIL rstmid_reach_beat4 got %0d want 3", nbeat);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({arvalid, rready, resp_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL rstmid_abort got %b want 000", {arvalid, rready, resp_valid});
        end
        rst = 1'b0;
        model_clear();
        a = $urandom;
        refill(a);
        model_apply(a, LW);
        n_cmp++;
        if (obs_data !== model_flat() || obs_lat !== 11 || obs_to !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_recover data %h lat %0d want %h 11", obs_data, obs_lat, model_flat());
        end
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_basic();
        test_ar_stall();
        test_gaps();
        test_random();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
